// File: rtl/ram_burst_pkg.sv
// Shared types and default sizes for the RAM burst initiator.
// Default sizes match the 128x32 single-port RAM.
package ram_burst_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 7;
  localparam int unsigned DEF_LEN_WIDTH  = 8;
  localparam int unsigned MAX_LEN        = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for the 128x32 single-port RAM: streams words in (write burst)
// or out (read burst) between valid/ready handshakes and the RAM port.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [LEN_WIDTH-1:0]  LEN_MAX  = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_load;
  logic                    rd_drain_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    done        = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_d       = '0;
    rd_load     = 1'b0;
    rd_drain_ok = !rd_valid_q || rd_ready;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
          if (cmd_len == '0)  state_d = ST_DONE;
          else if (cmd_write) state_d = ST_WRITE;
          else                state_d = ST_READ;
        end
      end

      ST_WRITE: begin
        wr_ready = 1'b1;
        ram_addr = addr_q;
        ram_d    = wr_data;
        ram_we   = wr_valid;
        if (wr_valid) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = ST_DONE;
        end
      end

      ST_READ: begin
        ram_addr = addr_q;
        // The output slot refills in the same cycle it drains, so a held-high
        // rd_ready sustains one word per cycle.
        rd_load  = (rem_q != '0) && rd_drain_ok;
        if (rd_load) begin
          rd_data_d  = ram_q;
          rd_valid_d = 1'b1;
          addr_d     = addr_q + ADDR_ONE;
          rem_d      = rem_q - LEN_ONE;
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
        end
        if ((rem_q == '0) && rd_drain_ok) state_d = ST_DONE;
      end

      ST_DONE: begin
        ram_addr = addr_q;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized bench for ram_burst_ctrl with a behavioural 128x32 RAM behind it
// and an array-based reference image of the RAM contents.
module tb_ram_burst_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int LW    = 8;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready;
  logic          busy, done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d, ram_q;

  always #5 clk = ~clk;

  ram_burst_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .busy     (busy),
    .done     (done),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  // RAM128x32: synchronous write, combinational read
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_d;
  assign ram_q = ram[ram_addr];

  logic [DW-1:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive_junk_cmd();
    cmd_valid = ($urandom_range(0, 3) == 0);
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = LW'($urandom);
  endtask

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(negedge clk);
    #1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk);
  endtask

  task automatic check_after_done();
    @(negedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(cmd_ready), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  // base != 0 gives words base, base+1, ...; otherwise random words
  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input int stall_pct, input logic [31:0] base);
    int            eff;
    int            idx;
    int            k;
    bit            got_done;
    logic [DW-1:0] words [$];
    eff = (int'(l) > DEPTH) ? DEPTH : int'(l);
    idx = 0;
    k = 0;
    got_done = 1'b0;
    for (int i = 0; i < eff; i++) words.push_back((base != 0) ? base + 32'(i) : $urandom);
    issue_cmd(1'b1, a, l);
    while (k < 1000) begin
      @(negedge clk);
      k++;
      drive_junk_cmd();
      wr_valid = ($urandom_range(0, 99) >= stall_pct);
      wr_data  = (idx < eff) ? words[idx] : $urandom;
      #1;
      if (done) begin
        got_done  = 1'b1;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        check("we_low_in_done", 32'(ram_we), 32'd0);
        break;
      end
      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      check("wr_ready_write", 32'(wr_ready), 32'd1);
      check("we_follows_valid", 32'(ram_we), 32'(wr_valid));
      if (ram_we) begin
        check("wr_addr", 32'(ram_addr), 32'((int'(a) + idx) % DEPTH));
        check("wr_data", ram_d, (idx < eff) ? words[idx] : 32'hDEAD_BEEF);
        idx++;
      end
    end
    wr_valid = 1'b0;
    cmd_valid = 1'b0;
    check("write_done_seen", 32'(got_done), 32'd1);
    check("write_count", 32'(idx), 32'(eff));
    if (stall_pct == 0) check("write_done_cycle", 32'(k), 32'(eff + 1));
    for (int i = 0; i < idx && i < eff; i++) ref_mem[(int'(a) + i) % DEPTH] = words[i];
    check_after_done();
  endtask

  // mode 0: rd_ready held high, 1: random, 2: pattern 1,0,0,1,0,0,...
  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input int mode);
    int            eff;
    int            idx;
    int            k;
    int            last_hs;
    int            first_valid;
    bit            got_done;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    eff = (int'(l) > DEPTH) ? DEPTH : int'(l);
    idx = 0;
    k = 0;
    last_hs = 0;
    first_valid = 0;
    got_done = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    issue_cmd(1'b0, a, l);
    while (k < 2000) begin
      @(negedge clk);
      k++;
      drive_junk_cmd();
      wr_valid = 1'($urandom);
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = (k % 3 == 1);
      endcase
      #1;
      check("read_no_we", 32'(ram_we), 32'd0);
      if (done) begin
        got_done  = 1'b1;
        cmd_valid = 1'b0;
        break;
      end
      check("wr_ready_read", 32'(wr_ready), 32'd0);
      if (rd_valid) begin
        if (first_valid == 0) first_valid = k;
        if (prev_stall) check("rd_hold", rd_data, prev_data);
        if (rd_ready) begin
          if (idx < eff) check("rd_data", rd_data, ref_mem[(int'(a) + idx) % DEPTH]);
          else check("rd_extra_word", 32'(idx), 32'(eff));
          idx++;
          last_hs = k;
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end
    rd_ready  = 1'b0;
    wr_valid  = 1'b0;
    cmd_valid = 1'b0;
    check("read_done_seen", 32'(got_done), 32'd1);
    check("read_count", 32'(idx), 32'(eff));
    if (eff > 0) begin
      check("read_done_after_last", 32'(k), 32'(last_hs + 1));
      if (mode == 0) check("read_first_valid", 32'(first_valid), 32'd2);
    end else begin
      check("len0_done_cycle", 32'(k), 32'd1);
      check("len0_no_rd_valid", 32'(first_valid), 32'd0);
    end
    check_after_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_d"}, ram_d, 32'd0);
  endtask

  task automatic reset_mid_write(input logic [AW-1:0] a);
    logic [DW-1:0] words [6];
    int            idx;
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    idx = 0;
    issue_cmd(1'b1, a, 8'd6);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = words[idx];
      #1;
      if (ram_we) idx++;
    end
    @(negedge clk);
    wr_data = words[2];
    #1;
    check("pre_reset_we", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("rst_no_done", 32'(done), 32'd0);
    end
    wr_valid = 1'b0;
    rst_n = 1'b1;
    check("reset_words_written", 32'(idx), 32'd2);
    for (int i = 0; i < idx; i++) ref_mem[(int'(a) + i) % DEPTH] = words[i];
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_write(7'h00, 8'd128, 0, 32'h0);
    do_write(7'h10, 8'd4, 0, 32'hA0);
    for (int i = 0; i < 4; i++) check("ram_a0_block", ram[16 + i], 32'hA0 + 32'(i));
    do_read(7'h10, 8'd4, 0);
    do_read(7'h10, 8'd3, 2);
    do_write(7'h7E, 8'd4, 0, 32'hB0);
    check("wrap_7e", ram[126], 32'hB0);
    check("wrap_7f", ram[127], 32'hB1);
    check("wrap_00", ram[0], 32'hB2);
    check("wrap_01", ram[1], 32'hB3);
    do_read(7'h7E, 8'd4, 1);
    do_write(7'h33, 8'd0, 0, 32'h0);
    do_read(7'h44, 8'd0, 0);
    do_write(7'h20, 8'd200, 0, 32'h0);
    do_read(7'h05, 8'd200, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom), LW'($urandom_range(0, 140)), int'($urandom_range(0, 50)), 32'h0);
      else
        do_read(AW'($urandom), LW'($urandom_range(0, 140)), 1);
    end

    reset_mid_write(7'h50);
    do_read(7'h00, 8'd128, 1);
    for (int i = 0; i < DEPTH; i++) check("final_ram", ram[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
